// File: rtl/fifo_sync_if.sv
// Push/pop handshake bundle for fifo_sync; the producer/consumer side is master.
interface fifo_sync_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  rd;
  logic                  empty;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output wr, din, rd, input full, empty, dout);
  modport slave  (input wr, din, rd, output full, empty, dout);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered (non-lookahead) read port.
// Pointers carry one extra wrap bit so full and empty are told apart
// without an occupancy counter.
module fifo_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input logic       clk,
  input logic       rst,
  fifo_sync_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  empty_c;
  logic                  full_c;
  logic                  wr_en_c;
  logic                  rd_en_c;

  assign waddr = wptr[DEPTH_LOG2-1:0];
  assign raddr = rptr[DEPTH_LOG2-1:0];

  // Flags depend only on registered pointers, never on wr/rd.
  assign empty_c = (wptr == rptr);
  assign full_c  = (waddr == raddr) && (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);

  assign wr_en_c = bus.wr && !full_c && !rst;
  assign rd_en_c = bus.rd && !empty_c;

  assign bus.full  = full_c;
  assign bus.empty = empty_c;
  assign bus.dout  = dout_q;

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[waddr] <= bus.din;
    end
  end

  // Pointers and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      dout_q <= '0;
    end else begin
      if (wr_en_c) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (rd_en_c) begin
        rptr   <= rptr + PTR_W'(1);
        dout_q <= mem[raddr];
      end
    end
  end
endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync against a queue-based reference model.
module tb_fifo_sync;
  localparam int unsigned DW    = 32;
  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 1 << DL2;

  logic clk;
  logic rst;

  fifo_sync_if #(.DATA_WIDTH(DW)) bus ();

  fifo_sync #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     checks;
  int unsigned     failures;
  logic [DW-1:0]   model_q [$];
  logic [DW-1:0]   model_dout;
  logic [DW-1:0]   seen [$];
  logic [DW-1:0]   stream [8];
  bit              saw_ee;
  int              wi;
  int              guard;
  logic            wbit;
  logic            rbit;
  logic [DW-1:0]   wval;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic w, input logic rq, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rst     = r;
    bus.wr  = w;
    bus.rd  = rq;
    bus.din = d;
    @(posedge clk);
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      rd_ok = rq && (model_q.size() != 0);
      wr_ok = w && (model_q.size() != DEPTH);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    #1;
    chk("dout",  bus.dout, model_dout);
    chk("empty", DW'(bus.empty), DW'(model_q.size() == 0));
    chk("full",  DW'(bus.full),  DW'(model_q.size() == DEPTH));
    if (rd_ok) seen.push_back(bus.dout);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    model_dout = '0;
    saw_ee     = 1'b0;
    rst        = 1'b1;
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.din    = '0;
    stream     = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81, 32'hE2, 32'hA0, 32'h7A};

    // Reset with rd held, then rd on an empty FIFO.
    step(1'b1, 1'b0, 1'b1, '0);
    chk("rst_empty", DW'(bus.empty), 32'd1);
    chk("rst_full",  DW'(bus.full),  32'd0);
    chk("rst_dout",  bus.dout,       32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("rd_empty_dout", bus.dout, 32'd0);

    // Ordered stream with random read pacing.
    seen.delete();
    wi    = 0;
    guard = 0;
    while ((wi < 8 || model_q.size() != 0) && guard < 200) begin
      wbit = (wi < 8);
      rbit = 1'($urandom_range(0, 1));
      wval = wbit ? stream[wi] : '0;
      step(1'b0, wbit, rbit, wval);
      if (wbit) wi++;
      guard++;
    end
    chk("stream_timeout", DW'(guard < 200), 32'd1);
    chk("stream_count", DW'(seen.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) chk("stream_order", seen[i], stream[i]);
    end

    // Fill to full, overflow write ignored, drain in order.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    chk("fill_full", DW'(bus.full), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'hFF);
    chk("overflow_full", DW'(bus.full), 32'd1);
    seen.delete();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("drain_count", DW'(seen.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < seen.size()) chk("drain_order", seen[i], DW'(i));
    end
    chk("drain_empty", DW'(bus.empty), 32'd1);

    // Simultaneous wr/rd on empty: only the write happens.
    step(1'b0, 1'b1, 1'b1, 32'h33);
    chk("simul_empty_dout",  bus.dout, 32'h0F);
    chk("simul_empty_flag",  DW'(bus.empty), 32'd0);

    // Simultaneous wr/rd on full: only the read happens.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + DW'(i));
    chk("refill_full", DW'(bus.full), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'hEE);
    chk("simul_full_dout", bus.dout, 32'h33);
    chk("simul_full_flag", DW'(bus.full), 32'd0);
    seen.delete();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("post_full_count", DW'(seen.size()), 32'd15);
    foreach (seen[i]) if (seen[i] == 32'hEE) saw_ee = 1'b1;
    chk("ee_not_stored", DW'(saw_ee), 32'd0);
    for (int i = 0; i < 15; i++) begin
      if (i < seen.size()) chk("post_full_order", seen[i], 32'h100 + DW'(i));
    end

    // Wrap-around with occupancy held between 1 and 3.
    step(1'b0, 1'b1, 1'b0, $urandom);
    seen.delete();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b1, 1'b1, $urandom);
      end else begin
        step(1'b0, 1'b1, 1'b0, $urandom);
        if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 1'b0, $urandom);
        while (model_q.size() > 1) step(1'b0, 1'b0, 1'b1, '0);
      end
      chk("wrap_not_full", DW'(bus.full), 32'd0);
    end
    while (model_q.size() != 0) step(1'b0, 1'b0, 1'b1, '0);
    chk("wrap_reads", DW'(seen.size() >= 40), 32'd1);

    // Mid-operation reset discards queued entries.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h200 + DW'(i));
    step(1'b1, 1'b1, 1'b1, 32'h99);
    chk("midrst_empty", DW'(bus.empty), 32'd1);
    chk("midrst_full",  DW'(bus.full),  32'd0);
    chk("midrst_dout",  bus.dout,       32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h42);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("midrst_readback", bus.dout, 32'h42);
    chk("midrst_final_empty", DW'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Synchronous single-clock FIFO with non-lookahead (registered) read port.
- Read data appears on dout one clock after the read request is accepted.
- Used as a generic buffering primitive between producer/consumer logic in the same clock domain.
- Write side is a push interface gated by full; read side is a pop interface gated by empty.

Parameters:
- DATA_WIDTH, 32, width of din/dout in bits.
- DEPTH_LOG2, 4, log2 of storage depth; capacity is 2**DEPTH_LOG2 entries (16 by default).

Ports:
- clk    input   1           clock; all state changes on rising edge
- rst    input   1           reset, synchronous, active-high
- full   output  1           FIFO holds 2**DEPTH_LOG2 entries; writes ignored
- wr     input   1           write request; din pushed on the clock edge when wr && !full
- din    input   DATA_WIDTH  write data
- empty  output  1           FIFO holds 0 entries; reads ignored
- rd     input   1           read request; pop on the clock edge when rd && !empty
- dout   output  DATA_WIDTH  registered read data

Behaviour:
- Reset (rst=1 at posedge):
  - write/read pointers cleared; empty=1, full=0, dout=0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries; any rd/wr asserted in the reset cycle is ignored.
- Storage and pointers:
  - Storage is a 2**DEPTH_LOG2 x DATA_WIDTH array.
  - Write and read pointers are DEPTH_LOG2+1 bits wide (extra wrap bit).
  - Address is pointer[DEPTH_LOG2-1:0]; pointers wrap naturally modulo 2**(DEPTH_LOG2+1).
- Flags:
  - empty = (wptr == rptr); full = (addr bits equal && wrap bits differ).
  - Both are combinational from registered pointers only, with no combinational path from wr/rd.
- Write:
  - At posedge, if wr && !full: mem[waddr] <= din; wptr <= wptr+1.
  - wr while full: ignored; no state change and no error flag.
- Read (non-lookahead):
  - At posedge, if rd && !empty: dout <= mem[raddr]; rptr <= rptr+1.
  - dout holds its previous value when no read is accepted, including rd while empty.
  - Read latency is 1 cycle: data for a read accepted at edge N is valid on dout after edge N and remains until the next accepted read.
- Write-to-read latency:
  - Entry written at edge N clears empty after edge N.
  - The earliest read is sampled at edge N+1; data is visible after edge N+1.
  - No write-through/bypass to dout.
- Simultaneous wr && rd:
  - Neither full nor empty: both occur in the same cycle; occupancy unchanged.
  - Empty: write accepted, read ignored; empty deasserts next cycle.
  - Full: read accepted, write ignored; full deasserts next cycle.
- Ordering: strict first-in first-out; no data loss or duplication across pointer wrap-around.

Test Plan:
- Reset: hold rst=1 for 1 edge -> empty=1, full=0, dout=0; rd=1 during and after reset with no writes -> dout stays 0, empty stays 1.
- Ordered stream with random read pacing:
  - Write 0x5A,0xF6,0x09,0xC4,0x81,0xE2,0xA0,0x7A back-to-back with wr held, rd toggled randomly each cycle.
  - Each accepted read yields the next value in order on dout one cycle later; all 8 match, none skipped or repeated.
- Fill to full (DEPTH_LOG2=4):
  - Write 0x00..0x0F with rd=0 -> full=1 after 16th write.
  - A 17th write of 0xFF is ignored.
  - Draining 16 reads returns 0x00..0x0F, then empty=1.
- Simultaneous at boundaries:
  - On empty, wr=1 din=0x33 rd=1 -> only the write occurs; next cycle empty=0, dout unchanged.
  - On full, wr=1 din=0xEE rd=1 -> head value on dout, full=0, 0xEE not stored.
- Wrap-around: 40 interleaved write/read pairs with occupancy kept between 1 and 3 -> all values returned in order across multiple pointer wraps; flags never glitch to full.
- Mid-operation reset: with 5 entries queued, assert rst for one edge -> empty=1, full=0, dout=0; the next write of 0x42 then a read returns 0x42.
